output_stream_ctrl: RTL

Parametrised output stage that sits between the hard limiter and the streaming output port of the reconstruction pipeline. It gates limiter samples with the iteration controller's output-enable and buffers the enabled samples in a small FIFO. Backpressure is handled with a full ready/valid handshake. Emitted samples are framed with start-of-packet and end-of-packet markers at a fixed frame length.

---
 rtl/output_stream_ctrl.sv | 109 ++++++++++
 1 files changed

// File: rtl/output_stream_ctrl.sv
// Output stage between the hard limiter and the streaming output port.
// Samples are gated by the iteration controller's output-enable and buffered in
// a small circular FIFO. The FIFO drains over a ready/valid interface, and the
// emitted samples are framed with SOP/EOP markers at a fixed frame length.
module output_stream_ctrl #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned FRAME_LEN  = 256
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic [DATA_WIDTH-1:0]                 limiter_data,
  input  logic                                  limiter_valid,
  output logic                                  limiter_ready,
  input  logic                                  iter_output_enable,
  output logic [DATA_WIDTH-1:0]                 out_data,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic                                  out_startofpacket,
  output logic                                  out_endofpacket,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]       fifo_level,
  output logic [31:0]                           discard_count
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW = $clog2(FIFO_DEPTH + 1);
  // Keep the frame counter at least one bit wide so FRAME_LEN=1 still elaborates.
  localparam int unsigned CntW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  localparam logic [LvlW-1:0] FullLvl = LvlW'(FIFO_DEPTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(FRAME_LEN - 1);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0] level_q, level_d;
  logic [CntW-1:0] frame_cnt_q, frame_cnt_d;
  logic [31:0]     discard_q, discard_d;

  logic in_fire, out_fire, push, drop;

  // Handshake decode; ready depends only on reset and occupancy (no bypass when full).
  always_comb begin
    limiter_ready = ~reset & (level_q != FullLvl);
    out_valid     = (level_q != '0);
    in_fire       = limiter_valid & limiter_ready;
    out_fire      = out_valid & out_ready;
    push          = in_fire & iter_output_enable;
    drop          = in_fire & ~iter_output_enable;
  end

  // Next-state for pointers, occupancy, frame position and discard counter.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    frame_cnt_d = frame_cnt_q;
    discard_d   = discard_q;

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (out_fire) rd_ptr_d = rd_ptr_q + PtrW'(1);

    unique case ({push, out_fire})
      2'b10:   level_d = level_q + LvlW'(1);
      2'b01:   level_d = level_q - LvlW'(1);
      default: level_d = level_q;
    endcase

    if (out_fire) begin
      frame_cnt_d = (frame_cnt_q == LastCnt) ? '0 : frame_cnt_q + CntW'(1);
    end

    if (drop && (discard_q != '1)) discard_d = discard_q + 32'd1;
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      frame_cnt_q <= '0;
      discard_q   <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      frame_cnt_q <= frame_cnt_d;
      discard_q   <= discard_d;
    end
  end

  // Sample storage; contents need no reset since out_data is masked while empty.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= limiter_data;
  end

  // Output view of the head entry and frame markers, all from registered state.
  always_comb begin
    out_data          = out_valid ? mem_q[rd_ptr_q] : '0;
    out_startofpacket = out_valid & (frame_cnt_q == '0);
    out_endofpacket   = out_valid & (frame_cnt_q == LastCnt);
    fifo_level        = level_q;
    discard_count     = discard_q;
  end

endmodule
